// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM slave. Configurable data width, depth and wait
//            states. Supports hsize byte-lane writes, pipelined back-to-back
//            transfers and read-after-write forwarding.
// Options  : define AHB_SRAM_ERR_EN to return a two-cycle ERROR response for
//            out-of-range, oversize or misaligned transfers.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int              C_BYTES     = DATA_W / 8;
    localparam int              C_OFF_W     = $clog2(C_BYTES);
    localparam int              C_IDX_W     = $clog2(DEPTH);
    localparam int              C_WIDX_W    = ADDR_W - C_OFF_W;
    localparam logic [C_WIDX_W-1:0] C_DEPTH_W = C_WIDX_W'(DEPTH);
    localparam logic [2:0]      C_MAX_SIZE  = 3'(C_OFF_W);
    localparam logic [3:0]      C_WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                w_accept;
    logic                w_bus_err;
    logic                w_commit;
    logic                w_rd_load;
    logic [C_IDX_W-1:0]  w_bus_idx;
    logic [C_IDX_W-1:0]  w_cap_idx;
    logic [C_IDX_W-1:0]  w_rd_idx;
    logic [C_BYTES-1:0]  w_wr_strb;
    logic                w_unused_inputs;

    // Word index of a byte address; out-of-range indices wrap modulo DEPTH.
    function automatic logic [C_IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [C_WIDX_W-1:0] full;
        full     = a[ADDR_W-1:C_OFF_W];
        word_idx = C_IDX_W'(full % C_DEPTH_W);
    endfunction

    // A lane is written when it sits in the same size-aligned block as the
    // address offset; oversize transfers are clamped to the full bus width.
    function automatic logic [C_BYTES-1:0] lane_strobe(input logic [C_OFF_W-1:0] off,
                                                       input logic [2:0]         size);
        logic [2:0] sz;
        sz          = (size > C_MAX_SIZE) ? C_MAX_SIZE : size;
        lane_strobe = '0;
        for (int b = 0; b < C_BYTES; b++) begin
            lane_strobe[b] = ((C_OFF_W'(b) >> sz) == (off >> sz));
        end
    endfunction

`ifdef AHB_SRAM_ERR_EN
    // Transfer is rejected when it leaves the array, exceeds the bus width
    // or is not naturally aligned to its size.
    function automatic logic xfer_err(input logic [ADDR_W-1:0] a, input logic [2:0] size);
        logic [C_WIDX_W-1:0] full;
        logic [C_OFF_W-1:0]  off;
        logic [C_OFF_W-1:0]  mask;
        full     = a[ADDR_W-1:C_OFF_W];
        off      = a[C_OFF_W-1:0];
        mask     = C_OFF_W'((1 << size) - 1);
        xfer_err = (full >= C_DEPTH_W) || (size > C_MAX_SIZE) || ((off & mask) != '0);
    endfunction

    assign w_bus_err = xfer_err(haddr, hsize);
`else
    assign w_bus_err = 1'b0;
`endif

    // hburst/hprot/hmastlock carry no meaning for a plain RAM; htrans[0]
    // only separates NONSEQ from SEQ, which is irrelevant per-beat.
    assign w_unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

    assign w_accept  = hsel & hready & htrans[1];
    assign w_bus_idx = word_idx(haddr);
    assign w_cap_idx = word_idx(addr_q);
    assign w_wr_strb = lane_strobe(addr_q[C_OFF_W-1:0], size_q);
    assign w_commit  = (state_q == ST_DATA) && write_q;

    // Next-state, address-phase capture and bus handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        w_rd_load = 1'b0;
        w_rd_idx  = w_cap_idx;
        hreadyout = 1'b1;
        case (state_q)
            ST_WAIT: begin
                hreadyout = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = ST_DATA;
                    w_rd_load = !write_q;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                state_d   = ST_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all end with the slave ready, so a new
                // address phase may be taken on the same edge.
                state_d = ST_IDLE;
                if (w_accept) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    size_d  = hsize;
                    if (w_bus_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end else begin
                        // Zero-wait read: the word is fetched straight from
                        // the bus address on the accept edge.
                        state_d   = ST_DATA;
                        w_rd_load = !hwrite;
                        w_rd_idx  = w_bus_idx;
                    end
                end
            end
        endcase
`ifdef AHB_SRAM_ERR_EN
        hresp = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
        hresp = 1'b0;
`endif
    end

    // Byte-lane write of the word addressed in the finishing data phase.
    always_comb begin
        mem_d = mem_q;
        if (w_commit) begin
            for (int b = 0; b < C_BYTES; b++) begin
                if (w_wr_strb[b]) begin
                    mem_d[w_cap_idx][8*b +: 8] = hwdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is taken from the post-write array image, which forwards a
    // same-edge write into a back-to-back read of the same word.
    always_comb begin
        hrdata_d = hrdata_q;
        if (w_rd_load) begin
            hrdata_d = mem_d[w_rd_idx];
        end
    end

    assign hrdata = hrdata_q;

    // State, capture registers, read data and storage array.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            hrdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hrdata_q <= hrdata_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_slave
// Brief    : Self-checking bench for ahb_sram_slave. Three instances with
//            0, 2 and 3 wait states are driven by a pipelined AHB master and
//            compared against a word-array reference model.
// Options  : honours AHB_SRAM_ERR_EN for the expected ERROR behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int NI = 3;
    localparam logic [1:0] K_REAL  = 2'd0;
    localparam logic [1:0] K_IDLE  = 2'd1;
    localparam logic [1:0] K_BUSY  = 2'd2;
    localparam logic [1:0] K_UNSEL = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        seq;
        logic [2:0]  burst;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n_a     [NI];
    logic        hsel_a      [NI];
    logic [31:0] haddr_a     [NI];
    logic        hwrite_a    [NI];
    logic [2:0]  hsize_a     [NI];
    logic [2:0]  hburst_a    [NI];
    logic [3:0]  hprot_a     [NI];
    logic [1:0]  htrans_a    [NI];
    logic        hmastlock_a [NI];
    logic [31:0] hwdata_a    [NI];
    logic        hreadyout_a [NI];
    logic        hresp_a     [NI];
    logic [31:0] hrdata_a    [NI];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_m   [NI][16];
    logic [31:0] last_rd [NI];
    xfer_t       q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_sram_slave #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .DEPTH       (16),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .hclk      (clk),
            .hresetn   (rst_n_a[g]),
            .hsel      (hsel_a[g]),
            .haddr     (haddr_a[g]),
            .hwrite    (hwrite_a[g]),
            .hsize     (hsize_a[g]),
            .hburst    (hburst_a[g]),
            .hprot     (hprot_a[g]),
            .htrans    (htrans_a[g]),
            .hmastlock (hmastlock_a[g]),
            .hready    (hreadyout_a[g]),
            .hwdata    (hwdata_a[g]),
            .hreadyout (hreadyout_a[g]),
            .hresp     (hresp_a[g]),
            .hrdata    (hrdata_a[g])
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SRAM_ERR_EN
        return ((a / 4) >= 16) || (s > 3'd2) || ((a % (32'd1 << s)) != 0);
`else
        return (a === 32'hxxxx_xxxx) && (s === 3'bxxx);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic void model_write(input int k, input logic [31:0] a,
                                        input logic [2:0] s, input logic [31:0] d);
        int nb;
        int first;
        nb    = 1 << ((s > 3'd2) ? 2 : int'(s));
        first = (int'(a % 4) / nb) * nb;
        for (int j = first; j < first + nb; j++) begin
            mem_m[k][widx(a)][8*j +: 8] = d[8*j +: 8];
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic wr, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d, input logic seq,
                        input logic [2:0] burst);
        xfer_t it;
        it.kind = kind; it.wr = wr; it.addr = a; it.size = s;
        it.data = d; it.seq = seq; it.burst = burst;
        q.push_back(it);
    endtask

    task automatic drive_idle(input int k);
        hsel_a[k] = 1'b0; htrans_a[k] = 2'b00; haddr_a[k] = '0; hwrite_a[k] = 1'b0;
        hsize_a[k] = '0; hburst_a[k] = '0; hprot_a[k] = '0; hmastlock_a[k] = 1'b0;
    endtask

    task automatic drive_addr(input int k, input xfer_t it);
        hsel_a[k]   = (it.kind != K_UNSEL);
        case (it.kind)
            K_REAL:  htrans_a[k] = it.seq ? 2'b11 : 2'b10;
            K_IDLE:  htrans_a[k] = 2'b00;
            K_BUSY:  htrans_a[k] = 2'b01;
            default: htrans_a[k] = 2'b10;
        endcase
        haddr_a[k] = it.addr; hwrite_a[k] = it.wr; hsize_a[k] = it.size;
        hburst_a[k] = it.burst; hprot_a[k] = 4'(it.data[3:0]);
        hmastlock_a[k] = it.data[4];
    endtask

    // Pipelined master: drains q onto instance k, checking every cycle.
    task automatic run(input int k);
        xfer_t ap, dp;
        logic  ap_v, dp_v, rdy, e;
        int    waits, exp_w, cyc;
        logic [31:0] exp_d;
        ap = '0; dp = '0; ap_v = 1'b0; dp_v = 1'b0; e = 1'b0;
        waits = 0; exp_w = 0; cyc = 0;
        if (q.size() > 0) begin
            ap = q.pop_front(); ap_v = 1'b1; drive_addr(k, ap);
        end
        while ((ap_v || dp_v) && cyc < 500) begin
            @(negedge clk);
            rdy = hreadyout_a[k];
            check($sformatf("hreadyout[%0d]", k), {31'b0, rdy},
                  {31'b0, (!dp_v || (waits >= exp_w))});
            check($sformatf("hresp[%0d]", k), {31'b0, hresp_a[k]}, {31'b0, (dp_v && e)});
            if (!rdy) waits++;
            if (rdy && dp_v) begin
                if (!dp.wr) begin
                    exp_d = e ? last_rd[k] : mem_m[k][widx(dp.addr)];
                    check($sformatf("hrdata[%0d]@%h", k, dp.addr), hrdata_a[k], exp_d);
                    last_rd[k] = exp_d;
                end else if (!e) begin
                    model_write(k, dp.addr, dp.size, dp.data);
                end
            end
            @(posedge clk);
            #1;
            if (rdy) begin
                dp_v = 1'b0;
                if (ap_v && ap.kind == K_REAL) begin
                    dp = ap; dp_v = 1'b1; waits = 0;
                    e = is_err(ap.addr, ap.size);
                    exp_w = e ? 1 : wait_of(k);
                    if (ap.wr) hwdata_a[k] = ap.data;
                end
                if (q.size() > 0) begin
                    ap = q.pop_front(); ap_v = 1'b1; drive_addr(k, ap);
                end else begin
                    ap_v = 1'b0; drive_idle(k);
                end
            end
            cyc++;
        end
        check($sformatf("timeout[%0d]", k), {31'b0, (cyc < 500)}, 32'd1);
        q.delete();
        drive_idle(k);
    endtask

    function automatic xfer_t rnd_item();
        xfer_t it;
        int    r;
        int    nb;
        r       = int'($urandom_range(0, 9));
        it.kind = (r < 7) ? K_REAL : ((r == 7) ? K_IDLE : ((r == 8) ? K_BUSY : K_UNSEL));
        it.wr   = 1'($urandom_range(0, 1));
        it.size = 3'($urandom_range(0, 3));
`ifdef AHB_SRAM_ERR_EN
        it.addr = 32'($urandom_range(0, 79));
`else
        it.addr = 32'($urandom_range(0, 255));
`endif
        if ($urandom_range(0, 3) != 0) begin
            nb      = 1 << ((it.size > 3'd2) ? 2 : int'(it.size));
            it.addr = it.addr & ~32'(nb - 1);
        end
        it.data  = $urandom;
        it.seq   = 1'b0;
        it.burst = 3'($urandom_range(0, 7));
        return it;
    endfunction

    initial begin
        xfer_t it;
        for (int k = 0; k < NI; k++) begin
            rst_n_a[k] = 1'b0; hwdata_a[k] = '0; last_rd[k] = '0;
            drive_idle(k);
            for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_hreadyout[%0d]", k), {31'b0, hreadyout_a[k]}, 32'd1);
            check($sformatf("rst_hresp[%0d]", k), {31'b0, hresp_a[k]}, 32'd0);
            check($sformatf("rst_hrdata[%0d]", k), hrdata_a[k], 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst_n_a[k] = 1'b1;

        // Single word write then read, zero wait states.
        push(K_REAL, 1'b1, 32'h0, 3'd2, 32'h64, 1'b0, 3'd0);
        push(K_REAL, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 3'd0);
        run(0);
        check("single_word", hrdata_a[0], 32'h64);

        // Back-to-back write/read of the same word.
        push(K_REAL, 1'b1, 32'h8, 3'd2, 32'hA5A5A5A5, 1'b0, 3'd0);
        push(K_REAL, 1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 3'd0);
        run(0);
        check("fwd_b2b", hrdata_a[0], 32'hA5A5A5A5);

        // Byte-lane write into an existing word.
        push(K_REAL, 1'b1, 32'h4, 3'd2, 32'h11223344, 1'b0, 3'd0);
        push(K_REAL, 1'b1, 32'h6, 3'd0, 32'h00EE0000, 1'b0, 3'd0);
        push(K_REAL, 1'b0, 32'h4, 3'd2, 32'h0, 1'b0, 3'd0);
        run(0);
        check("byte_lane", hrdata_a[0], 32'h11EE3344);

        // Out-of-range read: ERROR with held data, or wrap to word 0.
        push(K_REAL, 1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 3'd0);
        run(0);
`ifdef AHB_SRAM_ERR_EN
        check("oob_read", hrdata_a[0], 32'h11EE3344);
`else
        check("oob_read", hrdata_a[0], 32'h64);
`endif

        // INCR4 burst with two wait states per beat, then read back.
        for (int i = 0; i < 4; i++)
            push(K_REAL, 1'b1, 32'h10 + 32'(4 * i), 3'd2, 32'(i + 1), (i != 0), 3'b011);
        for (int i = 0; i < 4; i++)
            push(K_REAL, 1'b0, 32'h10 + 32'(4 * i), 3'd2, 32'h0, (i != 0), 3'b011);
        run(1);
        check("incr4_last", hrdata_a[1], 32'd4);

        // Randomised pipelined traffic on every instance.
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 4; r++) begin
                for (int n = 0; n < 14; n++) begin
                    it = rnd_item();
                    q.push_back(it);
                end
                run(k);
            end
        end

        // Reset during the wait states of a pending write.
        it = '0; it.kind = K_REAL; it.wr = 1'b1; it.addr = 32'h8; it.size = 3'd2;
        drive_addr(2, it);
        @(posedge clk);
        #1;
        drive_idle(2);
        hwdata_a[2] = 32'hDEADBEEF;
        @(negedge clk);
        check("midwait_busy", {31'b0, hreadyout_a[2]}, 32'd0);
        rst_n_a[2] = 1'b0;
        #1;
        check("midwait_rst_ready", {31'b0, hreadyout_a[2]}, 32'd1);
        check("midwait_rst_resp", {31'b0, hresp_a[2]}, 32'd0);
        check("midwait_rst_rdata", hrdata_a[2], 32'd0);
        for (int i = 0; i < 16; i++) mem_m[2][i] = '0;
        last_rd[2] = '0;
        @(posedge clk);
        #1;
        rst_n_a[2] = 1'b1;
        push(K_REAL, 1'b1, 32'hC, 3'd2, 32'h5A5A5A5A, 1'b0, 3'd0);
        push(K_REAL, 1'b0, 32'hC, 3'd2, 32'h0, 1'b0, 3'd0);
        push(K_REAL, 1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 3'd0);
        run(2);
        check("midwait_discard", hrdata_a[2], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
